// File: rtl/id_ex_if.sv
`default_nettype none
// ============================================================================
// id_ex_if : decode -> ID/EX -> execute bundle, master = driver, slave = stage
// Revision : 1.0
// ============================================================================
interface id_ex_if #(
  parameter int XLEN = 32,
  parameter int RA_W = 5,
  parameter int OP_W = 4
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_npc;
  logic [XLEN-1:0] in_rdata1;
  logic [XLEN-1:0] in_rdata2;
  logic [XLEN-1:0] in_imm;
  logic [RA_W-1:0] in_rs1;
  logic [RA_W-1:0] in_rs2;
  logic [RA_W-1:0] in_rd;
  logic            in_wen;
  logic            in_is_load;
  logic            in_src1_pc;
  logic            in_src2_imm;
  logic [OP_W-1:0] in_alu_op;
  logic            flush;
  logic            ex_ready;
  logic            out_valid;
  logic [XLEN-1:0] out_npc;
  logic [XLEN-1:0] out_rdata1;
  logic [XLEN-1:0] out_rdata2;
  logic [XLEN-1:0] out_imm;
  logic [RA_W-1:0] out_rd;
  logic            out_wen;
  logic            out_is_load;
  logic [OP_W-1:0] out_alu_op;
  logic            out_mux1_s;
  logic            out_mux1_redir;
  logic            out_mux2_redir;
  logic            load_use_stall;

  modport master (
    output in_valid, in_npc, in_rdata1, in_rdata2, in_imm, in_rs1, in_rs2, in_rd,
           in_wen, in_is_load, in_src1_pc, in_src2_imm, in_alu_op, flush, ex_ready,
    input  in_ready, out_valid, out_npc, out_rdata1, out_rdata2, out_imm, out_rd,
           out_wen, out_is_load, out_alu_op, out_mux1_s, out_mux1_redir,
           out_mux2_redir, load_use_stall
  );

  modport slave (
    input  in_valid, in_npc, in_rdata1, in_rdata2, in_imm, in_rs1, in_rs2, in_rd,
           in_wen, in_is_load, in_src1_pc, in_src2_imm, in_alu_op, flush, ex_ready,
    output in_ready, out_valid, out_npc, out_rdata1, out_rdata2, out_imm, out_rd,
           out_wen, out_is_load, out_alu_op, out_mux1_s, out_mux1_redir,
           out_mux2_redir, load_use_stall
  );
endinterface
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// id_ex_stage : ID/EX register with handshake, flush, load-use stall, fwd select
// Revision    : 1.0
// ============================================================================
module id_ex_stage #(
  parameter int XLEN = 32,
  parameter int RA_W = 5,
  parameter int OP_W = 4
) (
  input  wire      clk,
  input  wire      rst,
  id_ex_if.slave   bus
);
  localparam logic [RA_W-1:0] C_X0 = '0;

  logic            valid_q,   valid_d;
  logic [XLEN-1:0] npc_q,     npc_d;
  logic [XLEN-1:0] rdata1_q,  rdata1_d;
  logic [XLEN-1:0] rdata2_q,  rdata2_d;
  logic [XLEN-1:0] imm_q,     imm_d;
  logic [RA_W-1:0] rd_q,      rd_d;
  logic            wen_q,     wen_d;
  logic            is_load_q, is_load_d;
  logic [OP_W-1:0] alu_op_q,  alu_op_d;
  logic            mux1_s_q,  mux1_s_d;
  logic            redir1_q,  redir1_d;
  logic            redir2_q,  redir2_d;

  logic w_lus, w_in_ready, w_fire_in, w_fire_out, w_fwd_ok;

  // Held load whose rd feeds a real register operand of the incoming instruction.
  assign w_lus = bus.in_valid & valid_q & is_load_q & wen_q & (rd_q != C_X0)
               & (((bus.in_rs1 == rd_q) & ~bus.in_src1_pc)
                | ((bus.in_rs2 == rd_q) & ~bus.in_src2_imm));

  assign w_in_ready = (~valid_q | bus.ex_ready) & ~w_lus & ~bus.flush;
  assign w_fire_in  = bus.in_valid & w_in_ready;
  assign w_fire_out = valid_q & bus.ex_ready;
  assign w_fwd_ok   = valid_q & wen_q & ~is_load_q & (rd_q != C_X0);

  always_comb begin
    valid_d   = valid_q;
    npc_d     = npc_q;
    rdata1_d  = rdata1_q;
    rdata2_d  = rdata2_q;
    imm_d     = imm_q;
    rd_d      = rd_q;
    wen_d     = wen_q;
    is_load_d = is_load_q;
    alu_op_d  = alu_op_q;
    mux1_s_d  = mux1_s_q;
    redir1_d  = redir1_q;
    redir2_d  = redir2_q;
    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (w_fire_in) begin
      valid_d   = 1'b1;
      npc_d     = bus.in_npc;
      rdata1_d  = bus.in_rdata1;
      rdata2_d  = bus.in_rdata2;
      imm_d     = bus.in_imm;
      rd_d      = bus.in_rd;
      wen_d     = bus.in_wen;
      is_load_d = bus.in_is_load;
      alu_op_d  = bus.in_alu_op;
      mux1_s_d  = bus.in_src1_pc;
      // A capture with valid_q set implies the held producer leaves this cycle.
      redir1_d  = w_fwd_ok & (bus.in_rs1 == rd_q) & ~bus.in_src1_pc;
      redir2_d  = w_fwd_ok & (bus.in_rs2 == rd_q) & ~bus.in_src2_imm;
    end else if (w_fire_out) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      npc_q     <= '0;
      rdata1_q  <= '0;
      rdata2_q  <= '0;
      imm_q     <= '0;
      rd_q      <= '0;
      wen_q     <= 1'b0;
      is_load_q <= 1'b0;
      alu_op_q  <= '0;
      mux1_s_q  <= 1'b0;
      redir1_q  <= 1'b0;
      redir2_q  <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      npc_q     <= npc_d;
      rdata1_q  <= rdata1_d;
      rdata2_q  <= rdata2_d;
      imm_q     <= imm_d;
      rd_q      <= rd_d;
      wen_q     <= wen_d;
      is_load_q <= is_load_d;
      alu_op_q  <= alu_op_d;
      mux1_s_q  <= mux1_s_d;
      redir1_q  <= redir1_d;
      redir2_q  <= redir2_d;
    end
  end

  assign bus.in_ready       = w_in_ready;
  assign bus.load_use_stall = w_lus;
  assign bus.out_valid      = valid_q;
  assign bus.out_npc        = npc_q;
  assign bus.out_rdata1     = rdata1_q;
  assign bus.out_rdata2     = rdata2_q;
  assign bus.out_imm        = imm_q;
  assign bus.out_rd         = rd_q;
  assign bus.out_wen        = wen_q;
  assign bus.out_is_load    = is_load_q;
  assign bus.out_alu_op     = alu_op_q;
  assign bus.out_mux1_s     = mux1_s_q;
  assign bus.out_mux1_redir = redir1_q;
  assign bus.out_mux2_redir = redir2_q;
endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// tb_id_ex_stage : directed self-checking bench for id_ex_stage
// Revision       : 1.0
// ============================================================================
module tb_id_ex_stage;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  id_ex_if #(.XLEN(32), .RA_W(5), .OP_W(4)) bus ();

  id_ex_stage #(.XLEN(32), .RA_W(5), .OP_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] npc, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [31:0] imm,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic wen, input logic ld, input logic s1pc,
                       input logic s2imm, input logic [3:0] op);
    bus.in_valid    = v;
    bus.in_npc      = npc;
    bus.in_rdata1   = r1;
    bus.in_rdata2   = r2;
    bus.in_imm      = imm;
    bus.in_rs1      = rs1;
    bus.in_rs2      = rs2;
    bus.in_rd       = rd;
    bus.in_wen      = wen;
    bus.in_is_load  = ld;
    bus.in_src1_pc  = s1pc;
    bus.in_src2_imm = s2imm;
    bus.in_alu_op   = op;
    #0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    bus.flush    = 1'b0;
    bus.ex_ready = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // ADD x5 <- x1,x2 then SUB x8 <- x5,x6: rs1 forwarded
    drive(1, 32'h100, 32'h11, 32'h22, 32'h0, 5'd1, 5'd2, 5'd5, 1, 0, 0, 0, 4'd1);
    step();
    chk("add_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("add_rd", {27'd0, bus.out_rd}, 32'd5);
    chk("add_npc", bus.out_npc, 32'h100);
    drive(1, 32'h104, 32'h55, 32'h66, 32'h0, 5'd5, 5'd6, 5'd8, 1, 0, 0, 0, 4'd2);
    chk("sub_in_ready", {31'd0, bus.in_ready}, 32'd1);
    step();
    chk("sub_redir1", {31'd0, bus.out_mux1_redir}, 32'd1);
    chk("sub_redir2", {31'd0, bus.out_mux2_redir}, 32'd0);
    chk("sub_rdata1", bus.out_rdata1, 32'h55);
    chk("sub_alu_op", {28'd0, bus.out_alu_op}, 32'd2);

    // LW x7 then ADD x9 <- x1,x7: one bubble, no forward of a load
    drive(1, 32'h108, 32'h70, 32'h0, 32'h4, 5'd3, 5'd0, 5'd7, 1, 1, 0, 1, 4'd0);
    step();
    chk("lw_is_load", {31'd0, bus.out_is_load}, 32'd1);
    drive(1, 32'h10c, 32'h1, 32'h77, 32'h0, 5'd1, 5'd7, 5'd9, 1, 0, 0, 0, 4'd1);
    chk("lu_stall", {31'd0, bus.load_use_stall}, 32'd1);
    chk("lu_in_ready", {31'd0, bus.in_ready}, 32'd0);
    step();
    chk("lu_bubble", {31'd0, bus.out_valid}, 32'd0);
    chk("lu_stall_clear", {31'd0, bus.load_use_stall}, 32'd0);
    chk("lu_ready_back", {31'd0, bus.in_ready}, 32'd1);
    step();
    chk("lu_add_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("lu_add_rd", {27'd0, bus.out_rd}, 32'd9);
    chk("lu_add_redir2", {31'd0, bus.out_mux2_redir}, 32'd0);

    // I4 x11 <- x9 (forwarded), then stall downstream for 3 cycles
    drive(1, 32'h110, 32'h9, 32'h0, 32'h0, 5'd9, 5'd0, 5'd11, 1, 0, 0, 1, 4'd3);
    step();
    chk("i4_redir1", {31'd0, bus.out_mux1_redir}, 32'd1);
    bus.ex_ready = 1'b0;
    drive(1, 32'h114, 32'hb, 32'h0, 32'h0, 5'd11, 5'd0, 5'd12, 1, 0, 0, 1, 4'd4);
    for (int i = 0; i < 3; i++) begin
      chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
      step();
      chk("stall_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("stall_rd", {27'd0, bus.out_rd}, 32'd11);
      chk("stall_npc", bus.out_npc, 32'h110);
      chk("stall_redir1", {31'd0, bus.out_mux1_redir}, 32'd1);
    end
    bus.ex_ready = 1'b1;
    #0;
    step();
    chk("i5_rd", {27'd0, bus.out_rd}, 32'd12);
    chk("i5_redir1", {31'd0, bus.out_mux1_redir}, 32'd1);

    // flush kills held and incoming
    bus.flush = 1'b1;
    drive(1, 32'h118, 32'h0, 32'h0, 32'h0, 5'd12, 5'd12, 5'd13, 1, 0, 0, 0, 4'd5);
    chk("flush_in_ready", {31'd0, bus.in_ready}, 32'd0);
    step();
    chk("flush_valid", {31'd0, bus.out_valid}, 32'd0);
    bus.flush = 1'b0;

    // x0 producer never forwards
    drive(1, 32'h200, 32'h0, 32'h0, 32'h0, 5'd1, 5'd2, 5'd0, 1, 0, 0, 0, 4'd1);
    step();
    drive(1, 32'h204, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd3, 1, 0, 0, 0, 4'd1);
    step();
    chk("x0_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("x0_redir1", {31'd0, bus.out_mux1_redir}, 32'd0);
    chk("x0_redir2", {31'd0, bus.out_mux2_redir}, 32'd0);
    // AUIPC-style consumer: rs1 matches x3 but operand 1 is PC
    drive(1, 32'h208, 32'h0, 32'h0, 32'h1000, 5'd3, 5'd4, 5'd13, 1, 0, 1, 1, 4'd0);
    step();
    chk("pc_redir1", {31'd0, bus.out_mux1_redir}, 32'd0);
    chk("pc_mux1_s", {31'd0, bus.out_mux1_s}, 32'd1);
    chk("pc_imm", bus.out_imm, 32'h1000);
    // rs2 forward, then same rs2 masked by immediate select
    drive(1, 32'h20c, 32'h0, 32'h0, 32'h0, 5'd1, 5'd13, 5'd14, 1, 0, 0, 0, 4'd1);
    step();
    chk("rs2_redir2", {31'd0, bus.out_mux2_redir}, 32'd1);
    chk("rs2_redir1", {31'd0, bus.out_mux1_redir}, 32'd0);
    drive(1, 32'h210, 32'h0, 32'h0, 32'h8, 5'd1, 5'd14, 5'd15, 1, 0, 0, 1, 4'd1);
    step();
    chk("imm_redir2", {31'd0, bus.out_mux2_redir}, 32'd0);

    // reset mid-stream
    chk("pre_rst_valid", {31'd0, bus.out_valid}, 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mid_rst_npc", bus.out_npc, 32'd0);
    chk("mid_rst_imm", bus.out_imm, 32'd0);
    chk("mid_rst_rd", {27'd0, bus.out_rd}, 32'd0);
    chk("mid_rst_wen", {31'd0, bus.out_wen}, 32'd0);
    chk("mid_rst_mux1_s", {31'd0, bus.out_mux1_s}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
